// File: rtl/encrypt_cfg_arbiter.sv
// encrypt_cfg_arbiter
// Shares one encrypt/decrypt wrapper between two requesters. The owning
// channel streams bytes into the wrapper; on an owner change the in-flight
// bytes are drained, the new owner's configuration word is written, and only
// then are the new owner's bytes issued. Results are routed back to the
// channel that issued them.
module encrypt_cfg_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [7:0]  data0,
    input  logic [31:0] cfg0,
    input  logic        req1,
    input  logic [7:0]  data1,
    input  logic [31:0] cfg1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        enable,
    output logic [7:0]  data_in_encrypt,
    output logic        cfg_wen,
    output logic [31:0] cfg_data_in,
    input  logic        decrypt_valid_out,
    input  logic [7:0]  decrypted_data,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        underflow_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CFG   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] BURST_MAX    = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] INFLIGHT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             owner_r;
    logic             owner_nxt_s;
    logic             resp_owner_r;
    logic             cfg_loaded_r;
    logic [CNT_W-1:0] burst_cnt_r;
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] inflight_nxt_s;

    logic             req_own_s;
    logic             req_oth_s;
    logic             burst_max_s;
    logic             inflight_ok_s;
    logic             switch_s;
    logic             grant_s;
    logic             rsp_ok_s;

    // Arbitration terms: who is asking, whether the owner must yield, and the grant itself.
    always_comb begin
        req_own_s     = owner_r ? req1 : req0;
        req_oth_s     = owner_r ? req0 : req1;
        burst_max_s   = (burst_cnt_r == BURST_MAX);
        // A response in this cycle frees a slot for a byte in the same cycle.
        inflight_ok_s = (inflight_r < INFLIGHT_MAX) || decrypt_valid_out;
        switch_s      = (state_r == ST_RUN) && req_oth_s && (!req_own_s || burst_max_s);
        grant_s       = (state_r == ST_RUN) && cfg_loaded_r && req_own_s && !switch_s && inflight_ok_s;
        // A response with nothing outstanding is an error, not a result.
        rsp_ok_s      = decrypt_valid_out && (inflight_r != CNT_ZERO);
        gnt0          = grant_s && !owner_r;
        gnt1          = grant_s && owner_r;
    end

    // In-flight byte count for the next cycle.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({grant_s, rsp_ok_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
            2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Next state and next owner.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (req0) begin
                    state_nxt_s = ST_CFG;
                    owner_nxt_s = 1'b0;
                end else if (req1) begin
                    state_nxt_s = ST_CFG;
                    owner_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CFG: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (switch_s) begin
                    state_nxt_s = ST_DRAIN;
                    owner_nxt_s = !owner_r;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_r == CNT_ZERO) begin
                    state_nxt_s = ST_CFG;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = 1'b0;
            end
        endcase
    end

    // Control state: FSM, owners, burst and in-flight counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            resp_owner_r <= 1'b0;
            cfg_loaded_r <= 1'b0;
            burst_cnt_r  <= CNT_ZERO;
            inflight_r   <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            inflight_r <= inflight_nxt_s;
            // The draining owner keeps its responses until the new owner is configured.
            if (state_nxt_s == ST_CFG) begin
                resp_owner_r <= owner_nxt_s;
            end
            if (state_r == ST_CFG) begin
                cfg_loaded_r <= 1'b1;
                burst_cnt_r  <= CNT_ZERO;
            end else if (state_r == ST_RUN && burst_max_s && !req_oth_s) begin
                // Nobody is waiting: start a fresh burst for the same owner.
                burst_cnt_r <= CNT_ZERO;
            end else if (grant_s && !burst_max_s) begin
                burst_cnt_r <= burst_cnt_r + CNT_ONE;
            end
        end
    end

    // Registered wrapper-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable          <= 1'b0;
            data_in_encrypt <= 8'd0;
            cfg_wen         <= 1'b0;
            cfg_data_in     <= 32'd0;
            rsp_valid0      <= 1'b0;
            rsp_valid1      <= 1'b0;
            rsp_data        <= 8'd0;
            busy            <= 1'b0;
            underflow_err   <= 1'b0;
        end else begin
            enable <= grant_s;
            if (grant_s) begin
                data_in_encrypt <= owner_r ? data1 : data0;
            end
            // The strobe is high exactly while the FSM sits in CFG.
            cfg_wen <= (state_nxt_s == ST_CFG);
            if (state_nxt_s == ST_CFG) begin
                cfg_data_in <= owner_nxt_s ? cfg1 : cfg0;
            end
            rsp_valid0 <= rsp_ok_s && !resp_owner_r;
            rsp_valid1 <= rsp_ok_s && resp_owner_r;
            if (rsp_ok_s) begin
                rsp_data <= decrypted_data;
            end
            busy <= (state_nxt_s != ST_IDLE) || (inflight_nxt_s != CNT_ZERO);
            if (decrypt_valid_out && (inflight_r == CNT_ZERO)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_cfg_arbiter.sv
// Testbench for encrypt_cfg_arbiter. A loop-back wrapper model returns each
// issued byte unchanged after a random delay; a scoreboard of (channel, byte)
// in grant order checks that every result returns to its requester in order.
module tb_encrypt_cfg_arbiter;

    localparam int MAXI = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  data0, data1;
    logic [31:0] cfg0, cfg1;
    logic        gnt0, gnt1;
    logic        enable;
    logic [7:0]  data_in_encrypt;
    logic        cfg_wen;
    logic [31:0] cfg_data_in;
    logic        decrypt_valid_out;
    logic [7:0]  decrypted_data;
    logic        rsp_valid0, rsp_valid1;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    // Wrapper model and scoreboard.
    logic [7:0]  wq[$];
    logic [8:0]  exp_q[$];
    bit          wrap_auto;
    int unsigned wrap_pct;
    bit          force_dv;
    int          inflight_m;
    logic        uf_m;
    logic [31:0] last_cfg;
    int          g0_cnt, g1_cnt, rsp0_cnt, rsp1_cnt, cfgw_cnt;
    logic        s_gnt0, s_gnt1, s_dv;

    always #5 clk = ~clk;

    encrypt_cfg_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .cfg0(cfg0),
        .req1(req1), .data1(data1), .cfg1(cfg1),
        .gnt0(gnt0), .gnt1(gnt1),
        .enable(enable), .data_in_encrypt(data_in_encrypt),
        .cfg_wen(cfg_wen), .cfg_data_in(cfg_data_in),
        .decrypt_valid_out(decrypt_valid_out), .decrypted_data(decrypted_data),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
        .busy(busy), .underflow_err(underflow_err)
    );

    task automatic clear_model();
        wq.delete();
        exp_q.delete();
        inflight_m = 0;
        uf_m = 1'b0;
        last_cfg = 32'd0;
        g0_cnt = 0; g1_cnt = 0; rsp0_cnt = 0; rsp1_cnt = 0; cfgw_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        decrypt_valid_out = 1'b0; decrypted_data = 8'd0;
        wrap_auto = 1'b0; wrap_pct = 100; force_dv = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive the wrapper response, sample grants, then check
    // the registered outputs produced by the edge. Starts and ends at negedge.
    task automatic tick();
        int         infl_prev;
        logic       g, gch, dv_ok;
        logic [7:0] gdata;
        logic [8:0] e;
        if (force_dv) begin
            decrypt_valid_out = 1'b1; decrypted_data = 8'hEE;
        end else if (wrap_auto && wq.size() > 0 && $urandom_range(0, 99) < wrap_pct) begin
            decrypt_valid_out = 1'b1; decrypted_data = wq.pop_front();
        end else begin
            decrypt_valid_out = 1'b0; decrypted_data = 8'($urandom);
        end
        #1;
        s_gnt0 = gnt0; s_gnt1 = gnt1; s_dv = decrypt_valid_out;
        checks++;
        if (s_gnt0 && s_gnt1) begin
            errors++; $display("FAIL dual_grant: gnt0=%b gnt1=%b, required at most one", s_gnt0, s_gnt1);
        end
        checks++;
        if ((s_gnt0 && !req0) || (s_gnt1 && !req1)) begin
            errors++; $display("FAIL grant_without_req: gnt=%b%b req=%b%b", s_gnt1, s_gnt0, req1, req0);
        end
        g     = s_gnt0 || s_gnt1;
        gch   = s_gnt1;
        gdata = gch ? data1 : data0;
        infl_prev = inflight_m;
        if (g) begin
            checks++;
            if (infl_prev >= MAXI && !s_dv) begin
                errors++; $display("FAIL inflight_limit: grant with %0d in flight, required no grant", infl_prev);
            end
            checks++;
            if (last_cfg !== (gch ? cfg1 : cfg0)) begin
                errors++; $display("FAIL cfg_before_grant: last cfg %h, required %h", last_cfg, gch ? cfg1 : cfg0);
            end
            exp_q.push_back({gch, gdata});
            if (gch) g1_cnt++; else g0_cnt++;
        end
        dv_ok = s_dv && (infl_prev > 0);
        if (s_dv && infl_prev == 0) uf_m = 1'b1;
        inflight_m = infl_prev + (g ? 1 : 0) - (dv_ok ? 1 : 0);
        @(posedge clk);
        #1;
        checks++;
        if (enable !== g) begin
            errors++; $display("FAIL enable: got %b, required %b", enable, g);
        end
        if (g) begin
            checks++;
            if (data_in_encrypt !== gdata) begin
                errors++; $display("FAIL issue_data: got %h, required %h", data_in_encrypt, gdata);
            end
        end
        if (enable) wq.push_back(data_in_encrypt);
        checks++;
        if (cfg_wen && enable) begin
            errors++; $display("FAIL cfg_wen_with_enable: cfg_wen=%b enable=%b", cfg_wen, enable);
        end
        if (cfg_wen) begin
            cfgw_cnt++;
            last_cfg = cfg_data_in;
            checks++;
            if (inflight_m != 0) begin
                errors++; $display("FAIL cfg_wen_inflight: %0d bytes in flight, required 0", inflight_m);
            end
        end
        checks++;
        if (((rsp_valid0 | rsp_valid1) !== dv_ok) || (rsp_valid0 && rsp_valid1)) begin
            errors++; $display("FAIL rsp_valid: got %b%b, required one-hot=%b", rsp_valid1, rsp_valid0, dv_ok);
        end else if (dv_ok) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rsp_route: got %b/%h, required no response", rsp_valid1, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_valid1, rsp_data} !== e) begin
                    errors++; $display("FAIL rsp_route: got ch%0d/%h, required ch%0d/%h", rsp_valid1, rsp_data, e[8], e[7:0]);
                end
            end
            if (rsp_valid1) rsp1_cnt++; else rsp0_cnt++;
        end
        checks++;
        if (underflow_err !== uf_m) begin
            errors++; $display("FAIL underflow_err: got %b, required %b", underflow_err, uf_m);
        end
        checks++;
        if (inflight_m != 0 && busy !== 1'b1) begin
            errors++; $display("FAIL busy: got %b with %0d in flight, required 1", busy, inflight_m);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        wrap_auto = 1'b1; wrap_pct = 100;
        req0 = 1'b0; req1 = 1'b0;
        repeat (n) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        cfg0 = 32'd0; cfg1 = 32'd0; data0 = 8'd0; data1 = 8'd0;
        do_reset();
        checks++;
        if ({gnt0, gnt1, enable, data_in_encrypt, cfg_wen, cfg_data_in, rsp_valid0, rsp_valid1,
             rsp_data, busy, underflow_err} !== 56'd0) begin
            errors++; $display("FAIL reset_outputs: nonzero output after reset, required all 0");
        end
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || cfgw_cnt != 0) begin
            errors++; $display("FAIL idle_quiet: busy=%b cfg writes=%0d, required 0/0", busy, cfgw_cnt);
        end
    endtask

    task automatic test_single_ch0();
        cfg0 = 32'hFAAFBA13; cfg1 = 32'h0BADF00D;
        data0 = 8'h11; req0 = 1'b1;
        tick();
        checks++;
        if (cfg_wen !== 1'b1 || cfg_data_in !== 32'hFAAFBA13) begin
            errors++; $display("FAIL single_cfg: cfg_wen=%b cfg=%h, required 1/FAAFBA13", cfg_wen, cfg_data_in);
        end
        tick();
        checks++;
        if (s_gnt0 !== 1'b0) begin
            errors++; $display("FAIL single_cfg_cycle_grant: gnt0=%b, required 0", s_gnt0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_gnt0 !== 1'b1) begin
                errors++; $display("FAIL single_grant%0d: gnt0=%b, required 1", i, s_gnt0);
            end
            data0 = data0 + 8'd1;
        end
        drain(12);
        checks++;
        if (rsp0_cnt != 5 || rsp1_cnt != 0 || cfgw_cnt != 1) begin
            errors++; $display("FAIL single_counts: rsp0=%0d rsp1=%0d cfg=%0d, required 5/0/1", rsp0_cnt, rsp1_cnt, cfgw_cnt);
        end
    endtask

    task automatic test_resume();
        cfgw_cnt = 0;
        req0 = 1'b1; data0 = 8'h20;
        tick();
        checks++;
        if (s_gnt0 !== 1'b1) begin
            errors++; $display("FAIL resume_grant: gnt0=%b, required 1 without reconfiguring", s_gnt0);
        end
        data0 = 8'h21;
        repeat (2) tick();
        drain(8);
        checks++;
        if (cfgw_cnt != 0) begin
            errors++; $display("FAIL resume_cfg: %0d cfg writes, required 0", cfgw_cnt);
        end
    endtask

    task automatic test_alternate();
        int cur_ch, run_len, runs_done, ch;
        do_reset();
        cfg0 = $urandom | 32'd1; cfg1 = $urandom | 32'd2;
        req0 = 1'b1; req1 = 1'b1;
        wrap_auto = 1'b1; wrap_pct = 50;
        cur_ch = -1; run_len = 0; runs_done = 0;
        for (int t = 0; t < 150; t++) begin
            data0 = 8'($urandom); data1 = 8'($urandom);
            tick();
            if (s_gnt0 || s_gnt1) begin
                ch = s_gnt1 ? 1 : 0;
                if (ch != cur_ch) begin
                    checks++;
                    if (cur_ch == -1 && ch != 0) begin
                        errors++; $display("FAIL alt_first: first owner ch%0d, required ch0", ch);
                    end else if (cur_ch != -1 && run_len != 8) begin
                        errors++; $display("FAIL alt_burst: ch%0d got %0d grants, required 8", cur_ch, run_len);
                    end
                    if (cur_ch != -1) runs_done++;
                    cur_ch = ch; run_len = 1;
                end else begin
                    run_len++;
                end
            end
        end
        checks++;
        if (runs_done < 3) begin
            errors++; $display("FAIL alt_progress: %0d completed bursts, required at least 3", runs_done);
        end
        drain(40);
    endtask

    task automatic test_inflight_limit();
        do_reset();
        cfg0 = 32'h12345678; cfg1 = 32'h9ABCDEF0;
        req0 = 1'b1;
        for (int t = 0; t < 14; t++) begin
            data0 = 8'($urandom);
            tick();
        end
        checks++;
        if (g0_cnt != 8 || s_gnt0 !== 1'b0) begin
            errors++; $display("FAIL limit_stall: %0d grants gnt0=%b, required 8/0", g0_cnt, s_gnt0);
        end
        wrap_auto = 1'b1; wrap_pct = 100;
        for (int t = 0; t < 20 && g0_cnt < 12; t++) begin
            data0 = 8'($urandom);
            tick();
            checks++;
            if (!(s_dv && s_gnt0)) begin
                errors++; $display("FAIL limit_release: dv=%b gnt0=%b, required 1/1", s_dv, s_gnt0);
            end
            if (g0_cnt == 12) req0 = 1'b0;
        end
        checks++;
        if (g0_cnt != 12) begin
            errors++; $display("FAIL limit_total: %0d grants, required 12", g0_cnt);
        end
        drain(14);
    endtask

    task automatic test_underflow();
        int g_start;
        force_dv = 1'b1;
        tick();
        force_dv = 1'b0;
        repeat (3) tick();
        checks++;
        if (underflow_err !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky: got %b, required 1", underflow_err);
        end
        // A counter left at zero allows exactly the full in-flight budget.
        wrap_auto = 1'b0; req0 = 1'b1; g_start = g0_cnt;
        repeat (12) begin
            data0 = 8'($urandom);
            tick();
        end
        checks++;
        if (g0_cnt - g_start != 8) begin
            errors++; $display("FAIL underflow_counter: %0d grants, required 8", g0_cnt - g_start);
        end
        drain(14);
    endtask

    task automatic test_reset_drain();
        do_reset();
        cfg0 = $urandom | 32'd1; cfg1 = $urandom | 32'd4;
        req0 = 1'b1;
        for (int t = 0; t < 10 && g0_cnt < 3; t++) begin
            data0 = 8'($urandom);
            tick();
        end
        req0 = 1'b0; req1 = 1'b1;
        repeat (2) tick();
        checks++;
        if (inflight_m != 3) begin
            errors++; $display("FAIL rd_setup: %0d in flight, required 3", inflight_m);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, enable, data_in_encrypt, cfg_wen, cfg_data_in, rsp_valid0, rsp_valid1,
             rsp_data, busy, underflow_err} !== 56'd0) begin
            errors++; $display("FAIL rd_async_reset: nonzero output during reset, required all 0");
        end
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (s_gnt1 !== 1'b0 || cfg_wen !== 1'b1 || cfg_data_in !== cfg1) begin
            errors++; $display("FAIL rd_reconfig: gnt1=%b cfg_wen=%b cfg=%h, required 0/1/%h", s_gnt1, cfg_wen, cfg_data_in, cfg1);
        end
        tick();
        tick();
        checks++;
        if (s_gnt1 !== 1'b1) begin
            errors++; $display("FAIL rd_grant: gnt1=%b, required 1", s_gnt1);
        end
        drain(12);
    endtask

    task automatic test_random();
        do_reset();
        cfg0 = $urandom | 32'd1; cfg1 = $urandom | 32'd8;
        wrap_auto = 1'b1;
        for (int t = 0; t < 600; t++) begin
            if (t % 50 == 0) wrap_pct = $urandom_range(20, 95);
            if ($urandom_range(0, 99) < 15) req0 = !req0;
            if ($urandom_range(0, 99) < 15) req1 = !req1;
            data0 = 8'($urandom); data1 = 8'($urandom);
            tick();
        end
        drain(40);
        checks++;
        if (g0_cnt + g1_cnt != rsp0_cnt + rsp1_cnt || g0_cnt == 0 || g1_cnt == 0) begin
            errors++; $display("FAIL random_totals: grants %0d/%0d responses %0d/%0d", g0_cnt, g1_cnt, rsp0_cnt, rsp1_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_resume();
        test_alternate();
        test_inflight_limit();
        test_underflow();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
